// File: rtl/pattern_count_ctrl_if.sv
// Handshake/bus bundle for the serial pattern counter controller.
// master drives frame setup, serial data and result acceptance; slave is the controller.
interface pattern_count_ctrl_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 8
) ();
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] frame_len;
  logic             cin;
  logic             cin_valid;
  logic             cin_ready;
  logic             cout;
  logic             busy;
  logic [CNT_W-1:0] count;
  logic             done_valid;
  logic             done_ready;

  modport master (
    output start, pattern, frame_len, cin, cin_valid, done_ready,
    input  cin_ready, cout, busy, count, done_valid
  );

  modport slave (
    input  start, pattern, frame_len, cin, cin_valid, done_ready,
    output cin_ready, cout, busy, count, done_valid
  );
endinterface

// File: rtl/pattern_count_ctrl.sv
// Serial pattern detector sequencer: latches a pattern and frame length, accepts that many
// bits over valid/ready, counts overlapping matches (saturating) and hands back the count.
module pattern_count_ctrl #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned LEN_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  pattern_count_ctrl_if.slave bus
);

  localparam int unsigned FillW = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0] FillMax = FillW'(PAT_W);
  localparam logic [FillW-1:0] FillThr = FillW'(PAT_W - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] hist_q, hist_d;
  logic [FillW-1:0] fill_q, fill_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cout_q, cout_d;

  logic [PAT_W-1:0] window;
  logic             accept;

  // Candidate window with the incoming bit as LSB; the top history bit falls off.
  always_comb begin
    window = PAT_W'({hist_q, bus.cin});
    accept = (state_q == StRun) && bus.cin_valid;
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    cout_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cnt_d = '0;
          if (bus.frame_len != '0) begin
            pat_d   = bus.pattern;
            rem_d   = bus.frame_len;
            hist_d  = '0;
            fill_d  = '0;
            state_d = StRun;
          end else begin
            state_d = StDone;
          end
        end
      end
      StRun: begin
        if (accept) begin
          hist_d = window;
          fill_d = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          // Fill gate keeps stale/cleared history from producing early matches.
          if ((fill_q >= FillThr) && (window == pat_q)) begin
            cout_d = 1'b1;
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          if (rem_q == LEN_W'(1)) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.done_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.cin_ready  = (state_q == StRun);
  assign bus.busy       = (state_q != StIdle);
  assign bus.done_valid = (state_q == StDone);
  assign bus.cout       = cout_q;
  assign bus.count      = cnt_q;

endmodule
